// File: rtl/seg7_pkg.sv
// Shared types and glyph table for the multiplexed 7-segment driver.
// No logic of its own; constants and one pure function.
// Not applicable (no handshake).
package seg7_pkg;

    // All segments dark (active-low bus).
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} codes for hex digits 0..F.
    localparam logic [6:0] GLYPH_TAB [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        S_DARK  = 1'b0,
        S_DRIVE = 1'b1
    } fsm_t;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
        return GLYPH_TAB[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble to active-low 7-segment glyph.
// Purely combinational, zero latency.
// No flow control.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    assign glyph = hex_glyph(nibble);

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed multi-digit 7-segment driver with frame-atomic buffering.
// All pins registered: 1 cycle from state/index/display buffer to outputs.
// No backpressure; load is a strobe, last load in a frame wins.
// Optional macro SEG7_LZ_SUPPRESS_EN: blank leading zero digits (digit 0 never).
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int GUARD      = 500,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    fsm_t                    state;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;

    logic [4*NUM_DIGITS-1:0] pend_val;
    logic [NUM_DIGITS-1:0]   pend_blank;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [4*NUM_DIGITS-1:0] disp_val;
    logic [NUM_DIGITS-1:0]   disp_blank;
    logic [NUM_DIGITS-1:0]   disp_dp;

    logic [3:0]              cur_nib;
    logic                    cur_blank;
    logic                    cur_dp;
    logic                    cur_lz;
    logic [6:0]              cur_glyph;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic [NUM_DIGITS-1:0]   lz;
    logic                    slot_end;
    logic                    frame_end;
    logic                    lit;

    assign slot_end  = (state == S_DRIVE) && (cnt == CNT_W'(SCAN_DIV - 1));
    assign frame_end = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));

`ifdef SEG7_LZ_SUPPRESS_EN
    logic zero_run;

    // A digit is suppressed when it and every higher digit of the shown frame are zero.
    always_comb begin
        lz       = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run & (disp_val[4*i +: 4] == 4'h0);
            lz[i]    = zero_run;
        end
    end
`else
    assign lz = '0;
`endif

    // Select the current digit's nibble, masks and anode pattern from the display buffer.
    always_comb begin
        cur_nib   = 4'h0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        cur_lz    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_sel[i] = (idx != IDX_W'(i));
            if (idx == IDX_W'(i)) begin
                cur_nib   = disp_val[4*i +: 4];
                cur_blank = disp_blank[i];
                cur_dp    = disp_dp[i];
                cur_lz    = lz[i];
            end
        end
    end

    seg7_hex_decode u_dec (
        .nibble (cur_nib),
        .glyph  (cur_glyph)
    );

    assign lit = (state == S_DRIVE) && !cur_blank && !cur_lz;

    // Slot sequencer (dark guard, then drive) plus the registered pin drivers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_DARK;
            cnt        <= '0;
            idx        <= '0;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            an         <= '1;
            frame_tick <= 1'b0;
        end else begin
            case (state)
                S_DARK: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(GUARD - 1))
                        state <= S_DRIVE;
                end
                S_DRIVE: begin
                    if (slot_end) begin
                        cnt   <= '0;
                        idx   <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
                        state <= S_DARK;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= S_DARK;
            endcase
            seg        <= lit ? cur_glyph : SEG_OFF;
            an         <= lit ? an_sel : '1;
            dp         <= lit ? ~cur_dp : 1'b1;
            frame_tick <= frame_end;
        end
    end

    // Pending buffer collects loads; display buffer swaps only at the frame boundary,
    // taking a coincident load directly so it is not delayed by a whole frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_val   <= '0;
            pend_blank <= '0;
            pend_dp    <= '0;
            disp_val   <= '0;
            disp_blank <= '0;
            disp_dp    <= '0;
        end else begin
            if (load) begin
                pend_val   <= value;
                pend_blank <= blank_mask;
                pend_dp    <= dp_mask;
            end
            if (frame_end) begin
                disp_val   <= load ? value      : pend_val;
                disp_blank <= load ? blank_mask : pend_blank;
                disp_dp    <= load ? dp_mask    : pend_dp;
            end
        end
    end

endmodule
